// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared opcodes, FSM state encodings and ALU op codes for the multicycle controller
package riscv_ctrl_pkg;
  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;
  localparam logic [6:0] OP_RT  = 7'b0110011;
  localparam logic [6:0] OP_IT  = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  function automatic logic op_legal(input logic [6:0] op, input logic en_jal);
    return (op inside {OP_RT, OP_IT, OP_LW, OP_SW, OP_BEQ}) || (en_jal && op == OP_JAL);
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles; expired flags the limit cycle still waiting
module mem_wait_timer #(
  parameter int TIMEOUT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic busy,
  output logic expired
);
  logic [TIMEOUT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (busy) cnt <= cnt + 1'b1;
  end
  assign expired = busy && (&cnt);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle RISC-V style control FSM with memory-wait timeout and retire counter
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = 4,
  parameter int EN_JAL    = 1,
  parameter int RET_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             alusrc,
  output logic             regwrite,
  output logic             branch,
  output logic [1:0]       aluop,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [RET_W-1:0] retired
);
  state_t     st, nxt;
  logic [6:0] op_q;
  logic       armed, waiting, expired, retire;
  assign waiting = st == S_FETCH || st == S_MEM;
  mem_wait_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!waiting || mem_ready),
    .busy    (waiting && !mem_ready),
    .expired (expired)
  );
  always_comb begin
    nxt = st;
    case (st)
      S_RST:    nxt = armed ? S_FETCH : S_RST;
      S_FETCH:  nxt = mem_ready ? S_DECODE : expired ? S_TRAP : S_FETCH;
      S_DECODE: nxt = op_legal(opcode, EN_JAL != 0) ? S_EXEC : S_TRAP;
      S_EXEC:   nxt = op_q == OP_BEQ ? S_FETCH : (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
      S_MEM:    nxt = mem_ready ? (op_q == OP_LW ? S_WB : S_FETCH) : expired ? S_TRAP : S_MEM;
      S_WB:     nxt = S_FETCH;
      default:  nxt = S_TRAP;
    endcase
  end
  assign retire = nxt == S_FETCH && (st == S_EXEC || st == S_MEM || st == S_WB);
  // armed delays leaving RST by one edge so the first FETCH lands on the second edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_RST;
      armed   <= 1'b0;
      op_q    <= '0;
      retired <= '0;
    end else begin
      st    <= nxt;
      armed <= 1'b1;
      if (st == S_DECODE) op_q <= opcode;
      if (retire) retired <= retired + 1'b1;
    end
  end
  always_comb begin
    pc_write = 1'b0;
    ir_write = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    branch   = 1'b0;
    aluop    = ALU_ADD;
    illegal  = 1'b0;
    case (st)
      S_FETCH: begin
        memread  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        aluop    = op_q == OP_RT ? ALU_FUNCT : op_q == OP_BEQ ? ALU_SUB : ALU_ADD;
        alusrc   = op_q inside {OP_IT, OP_LW, OP_SW};
        branch   = op_q == OP_BEQ;
        pc_write = op_q == OP_JAL || (op_q == OP_BEQ && zero);
      end
      S_MEM: begin
        iord     = 1'b1;
        memread  = op_q == OP_LW;
        memwrite = op_q == OP_SW;
      end
      S_WB: begin
        regwrite = 1'b1;
        memtoreg = op_q == OP_LW;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end
  assign state = st;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scenario tasks checked against a per-instruction expected-trace model
module tb_multicycle_control;
  import riscv_ctrl_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [6:0]  opcode = '0;
  logic        pc_write, ir_write, iord, memread, memwrite, memtoreg, alusrc, regwrite, branch, illegal;
  logic [1:0]  aluop;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        pc_write_n, ir_write_n, iord_n, memread_n, memwrite_n, memtoreg_n, alusrc_n, regwrite_n, branch_n, illegal_n;
  logic [1:0]  aluop_n;
  logic [2:0]  state_n;
  logic [31:0] retired_n;
  logic [11:0] ctl;
  always #5 clk = ~clk;
  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .alusrc(alusrc), .regwrite(regwrite), .branch(branch), .aluop(aluop),
    .illegal(illegal), .state(state), .retired(retired)
  );
  multicycle_control #(.EN_JAL(0)) dut_nj (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write_n), .ir_write(ir_write_n), .iord(iord_n), .memread(memread_n), .memwrite(memwrite_n),
    .memtoreg(memtoreg_n), .alusrc(alusrc_n), .regwrite(regwrite_n), .branch(branch_n), .aluop(aluop_n),
    .illegal(illegal_n), .state(state_n), .retired(retired_n)
  );
  assign ctl = {pc_write, ir_write, iord, memread, memwrite, memtoreg, alusrc, regwrite, branch, aluop, illegal};
  typedef struct {
    logic [2:0]  st;
    logic [11:0] ctl;
    logic [31:0] ret;
    logic        rdy;
    logic        z;
    logic [6:0]  op;
  } cyc_t;
  cyc_t        q[$];
  logic [2:0]  obs_st[$], obs_st2[$];
  logic [11:0] obs_ctl[$];
  logic [31:0] obs_ret[$];
  logic        obs_ill2[$];
  logic [31:0] mret;
  int          n_cmp = 0, n_fail = 0;
  function automatic logic [11:0] mk(input logic pcw, irw, io, mr, mw, m2r, as, rw, br,
                                     input logic [1:0] ao, input logic ill);
    return {pcw, irw, io, mr, mw, m2r, as, rw, br, ao, ill};
  endfunction
  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction
  task automatic push(input logic [2:0] s, input logic [11:0] c, input logic r, input logic z, input logic [6:0] o);
    q.push_back('{s, c, mret, r, z, o});
  endtask
  task automatic push_trap(input int n);
    for (int i = 0; i < n; i++) push(S_TRAP, mk(0,0,0,0,0,0,0,0,0,2'b00,1), 1'($urandom), 1'($urandom), junk());
  endtask
  task automatic push_fetch_idle();
    push(S_FETCH, mk(0,0,0,1,0,0,0,0,0,2'b00,0), 1'b0, 1'($urandom), junk());
  endtask
  // One instruction's expected cycle trace, built from the per-state control rules
  task automatic add_instr(input logic [6:0] op, input logic z, input int fw, input int mw, output logic trapped);
    logic lw, sw, beq, jal, rt;
    logic [11:0] e;
    lw = op == OP_LW; sw = op == OP_SW; beq = op == OP_BEQ; jal = op == OP_JAL; rt = op == OP_RT;
    trapped = 1'b0;
    for (int i = 0; i <= fw && i < 16; i++) begin
      push(S_FETCH, mk(i == fw, i == fw, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0), i == fw, 1'($urandom), junk());
      if (i == 15 && fw > 15) trapped = 1'b1;
    end
    if (trapped) begin push_trap(1); return; end
    push(S_DECODE, '0, 1'($urandom), 1'($urandom), op);
    if (!(rt || lw || sw || beq || jal || op == OP_IT)) begin trapped = 1'b1; push_trap(1); return; end
    e = rt ? mk(0,0,0,0,0,0,0,0,0,2'b10,0) : beq ? mk(z,0,0,0,0,0,0,0,1,2'b01,0) :
        jal ? mk(1,0,0,0,0,0,0,0,0,2'b00,0) : mk(0,0,0,0,0,0,1,0,0,2'b00,0);
    push(S_EXEC, e, 1'($urandom), z, junk());
    if (beq) begin mret++; return; end
    if (lw || sw) begin
      for (int i = 0; i <= mw && i < 16; i++) begin
        push(S_MEM, mk(0, 0, 1, lw, sw, 0, 0, 0, 0, 2'b00, 0), i == mw, 1'($urandom), junk());
        if (i == 15 && mw > 15) trapped = 1'b1;
      end
      if (trapped) begin push_trap(1); return; end
      if (sw) begin mret++; return; end
    end
    push(S_WB, mk(0, 0, 0, 0, 0, lw, 0, 1, 0, 2'b00, 0), 1'($urandom), 1'($urandom), junk());
    mret++;
  endtask
  task automatic play();
    obs_st.delete(); obs_ctl.delete(); obs_ret.delete(); obs_st2.delete(); obs_ill2.delete();
    foreach (q[i]) begin
      @(negedge clk);
      mem_ready = q[i].rdy; zero = q[i].z; opcode = q[i].op;
      #1;
      obs_st.push_back(state); obs_ctl.push_back(ctl); obs_ret.push_back(retired);
      obs_st2.push_back(state_n); obs_ill2.push_back(illegal_n);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mret = 0;
    q.delete();
    push(S_RST, '0, 1'b0, 1'b0, '0);
  endtask
  task automatic test_reset();
    @(negedge clk);
    #1;
    n_cmp++;
    if ({state, ctl, retired} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: state=%0d ctl=%b ret=%0d, want all zero", state, ctl, retired);
    end
    do_reset();
    push_fetch_idle();
    push_fetch_idle();
    play();
    foreach (q[i]) begin
      n_cmp++;
      if (obs_st[i] !== q[i].st || obs_ctl[i] !== q[i].ctl || obs_ret[i] !== q[i].ret) begin
        n_fail++;
        $display("FAIL reset_release cyc%0d: st=%0d ctl=%b ret=%0d want st=%0d ctl=%b ret=%0d",
                 i, obs_st[i], obs_ctl[i], obs_ret[i], q[i].st, q[i].ctl, q[i].ret);
      end
    end
  endtask
  task automatic test_addi();
    logic t;
    do_reset();
    add_instr(OP_IT, 1'b0, 0, 0, t);
    push_fetch_idle();
    play();
    foreach (q[i]) begin
      n_cmp++;
      if (obs_st[i] !== q[i].st || obs_ctl[i] !== q[i].ctl || obs_ret[i] !== q[i].ret) begin
        n_fail++;
        $display("FAIL addi cyc%0d: st=%0d ctl=%b ret=%0d want st=%0d ctl=%b ret=%0d",
                 i, obs_st[i], obs_ctl[i], obs_ret[i], q[i].st, q[i].ctl, q[i].ret);
      end
    end
  endtask
  task automatic test_lw();
    logic t;
    do_reset();
    add_instr(OP_LW, 1'b0, 0, 3, t);
    push_fetch_idle();
    play();
    n_cmp++;
    if (q.size() != 10) begin
      n_fail++;
      $display("FAIL lw_len: trace=%0d want 10 (RST + 8 cycle instr + FETCH)", q.size());
    end
    foreach (q[i]) begin
      n_cmp++;
      if (obs_st[i] !== q[i].st || obs_ctl[i] !== q[i].ctl || obs_ret[i] !== q[i].ret) begin
        n_fail++;
        $display("FAIL lw cyc%0d: st=%0d ctl=%b ret=%0d want st=%0d ctl=%b ret=%0d",
                 i, obs_st[i], obs_ctl[i], obs_ret[i], q[i].st, q[i].ctl, q[i].ret);
      end
    end
  endtask
  task automatic test_beq();
    logic t;
    do_reset();
    add_instr(OP_BEQ, 1'b1, 0, 0, t);
    add_instr(OP_BEQ, 1'b0, 1, 0, t);
    push_fetch_idle();
    play();
    foreach (q[i]) begin
      n_cmp++;
      if (obs_st[i] !== q[i].st || obs_ctl[i] !== q[i].ctl || obs_ret[i] !== q[i].ret) begin
        n_fail++;
        $display("FAIL beq cyc%0d: st=%0d ctl=%b ret=%0d want st=%0d ctl=%b ret=%0d",
                 i, obs_st[i], obs_ctl[i], obs_ret[i], q[i].st, q[i].ctl, q[i].ret);
      end
    end
  endtask
  task automatic test_illegal();
    logic t;
    do_reset();
    add_instr(OP_IT, 1'b0, 0, 0, t);
    add_instr(7'b1111111, 1'b0, 0, 0, t);
    push_trap(5);
    play();
    foreach (q[i]) begin
      n_cmp++;
      if (obs_st[i] !== q[i].st || obs_ctl[i] !== q[i].ctl || obs_ret[i] !== q[i].ret) begin
        n_fail++;
        $display("FAIL illegal cyc%0d: st=%0d ctl=%b ret=%0d want st=%0d ctl=%b ret=%0d",
                 i, obs_st[i], obs_ctl[i], obs_ret[i], q[i].st, q[i].ctl, q[i].ret);
      end
    end
    do_reset();
    push_fetch_idle();
    play();
    n_cmp++;
    if (obs_ctl[1] !== q[1].ctl || obs_st[1] !== q[1].st) begin
      n_fail++;
      $display("FAIL illegal_clear: st=%0d ctl=%b want st=%0d ctl=%b", obs_st[1], obs_ctl[1], q[1].st, q[1].ctl);
    end
  endtask
  task automatic test_jal_disabled();
    logic t;
    logic [2:0] s2;
    do_reset();
    add_instr(OP_JAL, 1'b0, 0, 0, t);
    push_fetch_idle();
    play();
    foreach (q[i]) begin
      s2 = i < 3 ? q[i].st : 3'(S_TRAP);
      n_cmp++;
      if (obs_st[i] !== q[i].st || obs_ctl[i] !== q[i].ctl || obs_ret[i] !== q[i].ret) begin
        n_fail++;
        $display("FAIL jal cyc%0d: st=%0d ctl=%b ret=%0d want st=%0d ctl=%b ret=%0d",
                 i, obs_st[i], obs_ctl[i], obs_ret[i], q[i].st, q[i].ctl, q[i].ret);
      end
      n_cmp++;
      if (obs_st2[i] !== s2 || obs_ill2[i] !== (i >= 3)) begin
        n_fail++;
        $display("FAIL jal_disabled cyc%0d: st=%0d ill=%b want st=%0d ill=%b", i, obs_st2[i], obs_ill2[i], s2, i >= 3);
      end
    end
  endtask
  task automatic test_timeout();
    logic t;
    do_reset();
    add_instr(OP_SW, 1'b0, 0, 15, t);
    add_instr(OP_SW, 1'b0, 0, 99, t);
    push_trap(3);
    play();
    foreach (q[i]) begin
      n_cmp++;
      if (obs_st[i] !== q[i].st || obs_ctl[i] !== q[i].ctl || obs_ret[i] !== q[i].ret) begin
        n_fail++;
        $display("FAIL timeout cyc%0d: st=%0d ctl=%b ret=%0d want st=%0d ctl=%b ret=%0d",
                 i, obs_st[i], obs_ctl[i], obs_ret[i], q[i].st, q[i].ctl, q[i].ret);
      end
    end
    do_reset();
    add_instr(OP_IT, 1'b0, 15, 0, t);
    add_instr(OP_IT, 1'b0, 20, 0, t);
    push_trap(2);
    play();
    foreach (q[i]) begin
      n_cmp++;
      if (obs_st[i] !== q[i].st || obs_ctl[i] !== q[i].ctl || obs_ret[i] !== q[i].ret) begin
        n_fail++;
        $display("FAIL fetch_timeout cyc%0d: st=%0d ctl=%b ret=%0d want st=%0d ctl=%b ret=%0d",
                 i, obs_st[i], obs_ctl[i], obs_ret[i], q[i].st, q[i].ctl, q[i].ret);
      end
    end
  endtask
  task automatic test_random();
    logic t;
    logic [6:0] ops[6];
    ops = '{OP_RT, OP_IT, OP_LW, OP_SW, OP_BEQ, OP_JAL};
    do_reset();
    for (int k = 0; k < 40; k++)
      add_instr(ops[$urandom_range(0, 5)], 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 6), t);
    push_fetch_idle();
    play();
    foreach (q[i]) begin
      n_cmp++;
      if (obs_st[i] !== q[i].st || obs_ctl[i] !== q[i].ctl || obs_ret[i] !== q[i].ret) begin
        n_fail++;
        $display("FAIL random cyc%0d: st=%0d ctl=%b ret=%0d want st=%0d ctl=%b ret=%0d",
                 i, obs_st[i], obs_ctl[i], obs_ret[i], q[i].st, q[i].ctl, q[i].ret);
      end
      n_cmp++;
      if (obs_ctl[i][8] && obs_ctl[i][7]) begin
        n_fail++;
        $display("FAIL rd_wr_overlap cyc%0d: ctl=%b", i, obs_ctl[i]);
      end
    end
  endtask
  task automatic test_reset_mid_mem();
    logic t;
    do_reset();
    add_instr(OP_IT, 1'b0, 0, 0, t);
    add_instr(OP_LW, 1'b0, 0, 10, t);
    while (q.size() > 10) void'(q.pop_back());
    play();
    foreach (q[i]) begin
      n_cmp++;
      if (obs_st[i] !== q[i].st || obs_ctl[i] !== q[i].ctl || obs_ret[i] !== q[i].ret) begin
        n_fail++;
        $display("FAIL pre_reset cyc%0d: st=%0d ctl=%b ret=%0d want st=%0d ctl=%b ret=%0d",
                 i, obs_st[i], obs_ctl[i], obs_ret[i], q[i].st, q[i].ctl, q[i].ret);
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({state, ctl, retired} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: st=%0d ctl=%b ret=%0d want all zero", state, ctl, retired);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mret = 0;
    q.delete();
    push(S_RST, '0, 1'b0, 1'b0, '0);
    push_fetch_idle();
    play();
    foreach (q[i]) begin
      n_cmp++;
      if (obs_st[i] !== q[i].st || obs_ctl[i] !== q[i].ctl || obs_ret[i] !== q[i].ret) begin
        n_fail++;
        $display("FAIL post_reset cyc%0d: st=%0d ctl=%b ret=%0d want st=%0d ctl=%b ret=%0d",
                 i, obs_st[i], obs_ctl[i], obs_ret[i], q[i].st, q[i].ctl, q[i].ret);
      end
    end
  endtask
  initial begin
    test_reset();
    test_addi();
    test_lw();
    test_beq();
    test_illegal();
    test_jal_disabled();
    test_timeout();
    test_random();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
